// File: rtl/mem_stage_lsu_pkg.sv
// rtl/mem_stage_lsu_pkg.sv - BEOp codes, FSM state codes and op decode helpers for the MEM-stage LSU
package mem_stage_lsu_pkg;

   localparam logic [2:0] BE_SW  = 3'b000;
   localparam logic [2:0] BE_SH  = 3'b001;
   localparam logic [2:0] BE_SB  = 3'b010;
   localparam logic [2:0] BE_LW  = 3'b011;
   localparam logic [2:0] BE_LHU = 3'b100;
   localparam logic [2:0] BE_LH  = 3'b101;
   localparam logic [2:0] BE_LBU = 3'b110;
   localparam logic [2:0] BE_LB  = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

   function automatic size_e op_size(input logic [2:0] op);
      case (op)
         BE_SW, BE_LW:         return SZ_WORD;
         BE_SH, BE_LH, BE_LHU: return SZ_HALF;
         BE_SB, BE_LB, BE_LBU: return SZ_BYTE;
         default:              return SZ_BYTE;
      endcase
   endfunction

   function automatic logic op_signed(input logic [2:0] op);
      return (op == BE_LH) || (op == BE_LB);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane enables, store replication, load extraction/extension and misalign detect
module lsu_lane_align
   import mem_stage_lsu_pkg::*;
(
   input  logic [2:0]  be_op,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext,
   output logic        misalign
);

   size_e       size;
   logic        sext;
   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   always_comb begin
      size  = op_size(be_op);
      sext  = op_signed(be_op);
      rbyte = 8'(rdata >> {lane, 3'b000});
      rhalf = lane[1] ? rdata[31:16] : rdata[15:0];
      be        = 4'b1111;
      wdata_rep = wdata;
      rdata_ext = rdata;
      misalign  = 1'b0;
      case (size)
         SZ_BYTE: begin
            be        = 4'b0001 << lane;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {{24{sext & rbyte[7]}}, rbyte};
         end
         SZ_HALF: begin
            be        = lane[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {{16{sext & rhalf[15]}}, rhalf};
            misalign  = lane[0];
         end
         default: begin
            misalign  = (lane != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: req/ack bus FSM, timeout abort, pipeline stall
module mem_stage_lsu
   import mem_stage_lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  be_op_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        rdata_valid_o,
   output logic        misalign_o,
   output logic        bus_err_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i
);

   localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       op_q;
   logic [1:0]       lane_q;
   logic             we_q;
   logic [3:0]       be_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [31:0]      rdata_q;

   logic             in_idle, in_req, in_done, valid, launch, timeout_hit;
   logic [2:0]       al_op;
   logic [1:0]       al_lane;
   logic [3:0]       al_be;
   logic [31:0]      al_wdata, al_rdata;
   logic             al_mis;

   assign in_idle = (state == ST_IDLE);
   assign in_req  = (state == ST_REQ);
   assign in_done = (state == ST_DONE);
   assign valid   = mem_read_i | mem_write_i;

   // One aligner serves both phases: live inputs decode the request in IDLE,
   // the latched op/lane extract the returned word while in REQ.
   assign al_op   = in_idle ? be_op_i     : op_q;
   assign al_lane = in_idle ? addr_i[1:0] : lane_q;

   lsu_lane_align u_align (
      .be_op     (al_op),
      .lane      (al_lane),
      .wdata     (wdata_i),
      .rdata     (bus_rdata_i),
      .be        (al_be),
      .wdata_rep (al_wdata),
      .rdata_ext (al_rdata),
      .misalign  (al_mis)
   );

   assign launch      = rst_n & in_idle & valid & ~al_mis;
   assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt == CNT_W'(TO_LAST));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         op_q    <= '0;
         lane_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (launch) begin
                  state   <= ST_REQ;
                  cnt     <= '0;
                  op_q    <= be_op_i;
                  lane_q  <= addr_i[1:0];
                  we_q    <= mem_write_i;
                  be_q    <= al_be;
                  addr_q  <= {addr_i[31:2], 2'b00};
                  wdata_q <= al_wdata;
               end
            end
            ST_REQ: begin
               cnt <= cnt + CNT_W'(1);
               if (bus_ack_i) begin
                  rdata_q <= we_q ? 32'd0 : al_rdata;
                  state   <= ST_DONE;
               end else if (timeout_hit) begin
                  rdata_q <= 32'd0;
                  state   <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign stall_o       = launch | in_req;
   assign misalign_o    = rst_n & in_idle & valid & al_mis;
   assign bus_err_o     = in_req & ~bus_ack_i & timeout_hit;
   assign rdata_valid_o = in_done & ~we_q;
   assign rdata_o       = rdata_q;
   assign bus_req_o     = in_req;
   assign bus_we_o      = we_q;
   assign bus_addr_o    = addr_q;
   assign bus_be_o      = be_q;
   assign bus_wdata_o   = wdata_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu with directed load/store vectors
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_read_i, mem_write_i;
   logic [2:0]  be_op_i;
   logic [31:0] addr_i, wdata_i;
   logic        stall_o, rdata_valid_o, misalign_o, bus_err_o;
   logic [31:0] rdata_o;
   logic        bus_req_o, bus_we_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_be_o;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;

   always #5 clk = ~clk;

   mem_stage_lsu #(.TIMEOUT_CYCLES(16)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_read_i    (mem_read_i),
      .mem_write_i   (mem_write_i),
      .be_op_i       (be_op_i),
      .addr_i        (addr_i),
      .wdata_i       (wdata_i),
      .stall_o       (stall_o),
      .rdata_o       (rdata_o),
      .rdata_valid_o (rdata_valid_o),
      .misalign_o    (misalign_o),
      .bus_err_o     (bus_err_o),
      .bus_req_o     (bus_req_o),
      .bus_we_o      (bus_we_o),
      .bus_addr_o    (bus_addr_o),
      .bus_be_o      (bus_be_o),
      .bus_wdata_o   (bus_wdata_o),
      .bus_ack_i     (bus_ack_i),
      .bus_rdata_i   (bus_rdata_i)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        chk_wd;
   } bus_t;

   bus_t        exp_bus[$];
   logic [31:0] exp_rd[$];
   int          exp_stall[$];
   int          exp_err[$];
   int          exp_mis[$];

   int n_checks = 0;
   int n_pass   = 0;
   int quiet_mode = 0;
   int drv_timeouts = 0;
   bit finish_req = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Monitor: the only process that compares; the driver only pushes expectations.
   bus_t        cur;
   logic [31:0] s_addr, s_wdata;
   logic [3:0]  s_be;
   logic        s_we;
   logic        prev_req = 1'b0;
   int          req_n = 0;
   int          stall_run = 0;
   int          tmp;

   always @(negedge clk) begin
      if (quiet_mode == 1) begin
         chk("rst_stall", stall_o, 0);
         chk("rst_req", bus_req_o, 0);
         chk("rst_flags", {rdata_valid_o, misalign_o, bus_err_o, bus_we_o}, 0);
         chk("rst_rdata", rdata_o, 0);
         chk("rst_addr", bus_addr_o, 0);
         chk("rst_be_wdata", bus_wdata_o | 32'(bus_be_o), 0);
      end else if (quiet_mode == 2) begin
         chk("post_rst_req", bus_req_o, 0);
         chk("post_rst_stall", stall_o, 0);
      end
      if (!rst_n) begin
         stall_run = 0;
         prev_req  = 1'b0;
         req_n     = 0;
      end else begin
         if (bus_req_o && !prev_req) begin
            req_n = 1;
            s_addr = bus_addr_o; s_be = bus_be_o; s_we = bus_we_o; s_wdata = bus_wdata_o;
            if (exp_bus.size() == 0) chk("unexpected_req", 1, 0);
            else begin
               cur = exp_bus.pop_front();
               chk("bus_we", bus_we_o, cur.we);
               chk("bus_addr", bus_addr_o, cur.addr);
               chk("bus_be", bus_be_o, cur.be);
               if (cur.chk_wd) chk("bus_wdata", bus_wdata_o, cur.wdata);
            end
         end else if (bus_req_o) begin
            req_n++;
            chk("bus_stable", (bus_addr_o !== s_addr) || (bus_be_o !== s_be) ||
                              (bus_we_o !== s_we) || (bus_wdata_o !== s_wdata), 0);
         end
         prev_req = bus_req_o;
         if (rdata_valid_o) begin
            if (exp_rd.size() == 0) chk("unexpected_rdata", rdata_o, 32'hxxxx_xxxx);
            else chk("rdata", rdata_o, exp_rd.pop_front());
         end
         if (bus_err_o) begin
            if (exp_err.size() == 0) chk("unexpected_err", 1, 0);
            else chk("err_req_cycle", req_n, exp_err.pop_front());
         end
         if (misalign_o) begin
            if (exp_mis.size() == 0) chk("unexpected_misalign", 1, 0);
            else begin
               tmp = exp_mis.pop_front();
               chk("misalign_quiet", {bus_req_o, stall_o}, 0);
            end
         end
         if (stall_o) stall_run++;
         else if (stall_run > 0) begin
            if (exp_stall.size() == 0) chk("unexpected_stall", stall_run, 0);
            else chk("stall_cycles", stall_run, exp_stall.pop_front());
            stall_run = 0;
         end
      end
      if (finish_req) begin
         chk("left_bus", exp_bus.size(), 0);
         chk("left_rdata", exp_rd.size(), 0);
         chk("left_stall", exp_stall.size(), 0);
         chk("left_err", exp_err.size(), 0);
         chk("left_mis", exp_mis.size(), 0);
         chk("drv_timeouts", drv_timeouts, 0);
         $display("%0d/%0d checks passed", n_pass, n_checks);
         $finish;
      end
   end

   task automatic idle();
      mem_read_i = 0; mem_write_i = 0; be_op_i = 0; addr_i = 0; wdata_i = 0;
      bus_ack_i = 0; bus_rdata_i = 0;
   endtask

   // delay = REQ cycles before ack (0 = first REQ cycle); negative = never ack
   task automatic access(input logic rd, input logic wr, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int delay, input logic [31:0] rword);
      int n;
      bit fin;
      mem_read_i = rd; mem_write_i = wr; be_op_i = op; addr_i = addr; wdata_i = wd;
      bus_rdata_i = rword; bus_ack_i = 0;
      n = 0; fin = 0;
      for (int c = 0; c < 64 && !fin; c++) begin
         @(posedge clk); #1;
         if (bus_req_o) begin
            bus_ack_i = (n == delay);
            n++;
         end else begin
            bus_ack_i = 0;
            fin = 1;
         end
      end
      if (!fin) drv_timeouts++;
      @(posedge clk); #1;
   endtask

   task automatic push_bus(input logic we, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input logic cw);
      bus_t b;
      b.we = we; b.addr = a; b.be = be; b.wdata = wd; b.chk_wd = cw;
      exp_bus.push_back(b);
   endtask

   task automatic misaligned(input logic rd, input logic wr, input logic [2:0] op, input logic [31:0] addr);
      exp_mis.push_back(1);
      mem_read_i = rd; mem_write_i = wr; be_op_i = op; addr_i = addr; wdata_i = 32'h1;
      @(posedge clk); #1;
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      rst_n = 0;
      idle();
      repeat (2) @(posedge clk);
      #1 quiet_mode = 1;
      @(posedge clk); #1;
      quiet_mode = 0;
      rst_n = 1;
      @(posedge clk); #1;

      // SW word
      push_bus(1, 32'h100, 4'b1111, 32'hDEADBEEF, 1); exp_stall.push_back(2);
      access(0, 1, 3'b000, 32'h100, 32'hDEADBEEF, 0, 32'h0);
      // LB / LBU lane 3
      push_bus(0, 32'h100, 4'b1000, 0, 0); exp_rd.push_back(32'hFFFFFF80); exp_stall.push_back(2);
      access(1, 0, 3'b111, 32'h103, 0, 0, 32'h80FF_0000);
      push_bus(0, 32'h100, 4'b1000, 0, 0); exp_rd.push_back(32'h00000080); exp_stall.push_back(2);
      access(1, 0, 3'b110, 32'h103, 0, 0, 32'h80FF_0000);
      // SH upper half, then misaligned LH and SW
      push_bus(1, 32'h200, 4'b1100, 32'h12341234, 1); exp_stall.push_back(2);
      access(0, 1, 3'b001, 32'h202, 32'h0000_1234, 0, 32'h0);
      misaligned(1, 0, 3'b101, 32'h201);
      misaligned(0, 1, 3'b000, 32'h102);
      @(posedge clk); #1;
      // LH upper half with one wait state, LHU lower half
      push_bus(0, 32'h100, 4'b1100, 0, 0); exp_rd.push_back(32'hFFFF8001); exp_stall.push_back(3);
      access(1, 0, 3'b101, 32'h102, 0, 1, 32'h8001_0000);
      push_bus(0, 32'h100, 4'b0011, 0, 0); exp_rd.push_back(32'h00008001); exp_stall.push_back(2);
      access(1, 0, 3'b100, 32'h100, 0, 0, 32'h8001_8001);
      // SB lane 1 with two wait states, LB positive byte
      push_bus(1, 32'h100, 4'b0010, 32'hABABABAB, 1); exp_stall.push_back(4);
      access(0, 1, 3'b010, 32'h101, 32'h0000_00AB, 2, 32'h0);
      push_bus(0, 32'h100, 4'b0001, 0, 0); exp_rd.push_back(32'h0000007F); exp_stall.push_back(2);
      access(1, 0, 3'b111, 32'h100, 0, 0, 32'hFFFF_FF7F);
      // read and write both set: write wins, no load data
      push_bus(1, 32'h400, 4'b1111, 32'h55AA55AA, 1); exp_stall.push_back(3);
      access(1, 1, 3'b000, 32'h400, 32'h55AA55AA, 1, 32'h1234_5678);
      // LW timeout
      push_bus(0, 32'h500, 4'b1111, 0, 0); exp_err.push_back(16);
      exp_rd.push_back(32'h0); exp_stall.push_back(17);
      access(1, 0, 3'b011, 32'h500, 0, -1, 32'hFFFF_FFFF);
      idle();
      @(posedge clk); #1;

      // reset in the 3rd REQ cycle, then a late ack
      push_bus(0, 32'h600, 4'b1111, 0, 0);
      mem_read_i = 1; be_op_i = 3'b011; addr_i = 32'h600;
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 0;
      idle();
      @(posedge clk); #1;
      quiet_mode = 2;
      rst_n = 1;
      bus_ack_i = 1; bus_rdata_i = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      bus_ack_i = 0;
      @(posedge clk); #1;
      quiet_mode = 0;

      // back-to-back LW then SW
      push_bus(0, 32'h300, 4'b1111, 0, 0); exp_rd.push_back(32'hCAFEF00D); exp_stall.push_back(2);
      push_bus(1, 32'h304, 4'b1111, 32'h11223344, 1); exp_stall.push_back(5);
      access(1, 0, 3'b011, 32'h300, 0, 0, 32'hCAFEF00D);
      access(0, 1, 3'b000, 32'h304, 32'h11223344, 3, 32'h0);
      idle();
      repeat (3) @(posedge clk);
      #1 finish_req = 1'b1;
   end

endmodule
